// File: rtl/dot_product_pkg.sv
// Shared widths, payload types and loader state encoding for the dot-product front end.
package dot_product_pkg;

    localparam int unsigned N_ELEMS  = 8;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned RESULT_W = 64;
    localparam int unsigned IDX_W    = $clog2(N_ELEMS);

    typedef logic signed [DATA_W-1:0]   operand_t;
    typedef logic signed [RESULT_W-1:0] result_t;

    typedef enum logic [2:0] {
        LOAD,
        START,
        WAIT_LOW,
        WAIT_HIGH,
        OUTPUT
    } loader_state_t;

endpackage

// File: rtl/dot_product_stream_loader_watchdog.sv
// Cycle watchdog: clearable, enabled counter that saturates and flags TIMEOUT_CYCLES-1.
module dp_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             expired_q;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != LIMIT)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // expired_q always mirrors (count_q == LIMIT) so the flag comes straight from a flop
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= (count_d == LIMIT);
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/dot_product_stream_loader.sv
// Stream front end for dot_product_accel: buffers up to 8 operand pairs, starts the
// accelerator, follows the done 1->0->1 handshake and returns the result on a stream.
module dot_product_stream_loader #(
    parameter int unsigned DATA_W         = dot_product_pkg::DATA_W,
    parameter int unsigned RESULT_W       = dot_product_pkg::RESULT_W,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_W-1:0]   s_a,
    input  logic [DATA_W-1:0]   s_b,
    input  logic                s_last,
    output logic                acc_start,
    output logic [DATA_W-1:0]   acc_a0,
    output logic [DATA_W-1:0]   acc_a1,
    output logic [DATA_W-1:0]   acc_a2,
    output logic [DATA_W-1:0]   acc_a3,
    output logic [DATA_W-1:0]   acc_a4,
    output logic [DATA_W-1:0]   acc_a5,
    output logic [DATA_W-1:0]   acc_a6,
    output logic [DATA_W-1:0]   acc_a7,
    output logic [DATA_W-1:0]   acc_b0,
    output logic [DATA_W-1:0]   acc_b1,
    output logic [DATA_W-1:0]   acc_b2,
    output logic [DATA_W-1:0]   acc_b3,
    output logic [DATA_W-1:0]   acc_b4,
    output logic [DATA_W-1:0]   acc_b5,
    output logic [DATA_W-1:0]   acc_b6,
    output logic [DATA_W-1:0]   acc_b7,
    input  logic                acc_done,
    input  logic [RESULT_W-1:0] acc_result,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [RESULT_W-1:0] m_result,
    output logic                m_err,
    output logic                busy,
    output logic                timeout_err
);

    import dot_product_pkg::*;

    loader_state_t       state_q;
    loader_state_t       state_d;
    logic [IDX_W-1:0]    count_q;
    logic [DATA_W-1:0]   slot_a_q [N_ELEMS];
    logic [DATA_W-1:0]   slot_b_q [N_ELEMS];
    logic                acc_start_q;
    logic                m_valid_q;
    logic [RESULT_W-1:0] m_result_q;
    logic                m_err_q;
    logic                timeout_err_q;

    logic load_fire;
    logic vec_end;
    logic waiting;
    logic done_hit;
    logic timeout_hit;
    logic out_fire;
    logic wd_expired;

    assign load_fire   = s_valid && (state_q == LOAD);
    assign vec_end     = s_last || (count_q == IDX_W'(N_ELEMS - 1));
    assign waiting     = (state_q == WAIT_LOW) || (state_q == WAIT_HIGH);
    assign done_hit    = (state_q == WAIT_HIGH) && acc_done;
    // a completion seen in the same cycle as the watchdog limit takes priority
    assign timeout_hit = waiting && wd_expired && !done_hit;
    assign out_fire    = (state_q == OUTPUT) && m_valid_q && m_ready;

    dp_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q == START),
        .en_i      (waiting),
        .expired_o (wd_expired)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            LOAD:      if (load_fire && vec_end) state_d = START;
            START:     state_d = WAIT_LOW;
            WAIT_LOW: begin
                if (timeout_hit)    state_d = OUTPUT;
                else if (!acc_done) state_d = WAIT_HIGH;
            end
            WAIT_HIGH: if (done_hit || timeout_hit) state_d = OUTPUT;
            OUTPUT:    if (out_fire) state_d = LOAD;
            default:   state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= LOAD;
            count_q       <= '0;
            acc_start_q   <= 1'b0;
            m_valid_q     <= 1'b0;
            m_result_q    <= '0;
            m_err_q       <= 1'b0;
            timeout_err_q <= 1'b0;
            for (int i = 0; i < N_ELEMS; i++) begin
                slot_a_q[i] <= '0;
                slot_b_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            acc_start_q <= (state_d == START);
            if (load_fire) begin
                slot_a_q[count_q] <= s_a;
                slot_b_q[count_q] <= s_b;
                count_q           <= count_q + IDX_W'(1);
            end
            if (done_hit) begin
                m_result_q <= acc_result;
                m_err_q    <= 1'b0;
                m_valid_q  <= 1'b1;
            end else if (timeout_hit) begin
                m_result_q    <= '0;
                m_err_q       <= 1'b1;
                m_valid_q     <= 1'b1;
                timeout_err_q <= 1'b1;
            end
            // clearing the slots here is what zero-pads the next short vector
            if (out_fire) begin
                m_valid_q <= 1'b0;
                count_q   <= '0;
                for (int i = 0; i < N_ELEMS; i++) begin
                    slot_a_q[i] <= '0;
                    slot_b_q[i] <= '0;
                end
            end
        end
    end

    assign s_ready     = (state_q == LOAD);
    assign busy        = (state_q != LOAD);
    assign acc_start   = acc_start_q;
    assign m_valid     = m_valid_q;
    assign m_result    = m_result_q;
    assign m_err       = m_err_q;
    assign timeout_err = timeout_err_q;

    assign acc_a0 = slot_a_q[0];
    assign acc_a1 = slot_a_q[1];
    assign acc_a2 = slot_a_q[2];
    assign acc_a3 = slot_a_q[3];
    assign acc_a4 = slot_a_q[4];
    assign acc_a5 = slot_a_q[5];
    assign acc_a6 = slot_a_q[6];
    assign acc_a7 = slot_a_q[7];
    assign acc_b0 = slot_b_q[0];
    assign acc_b1 = slot_b_q[1];
    assign acc_b2 = slot_b_q[2];
    assign acc_b3 = slot_b_q[3];
    assign acc_b4 = slot_b_q[4];
    assign acc_b5 = slot_b_q[5];
    assign acc_b6 = slot_b_q[6];
    assign acc_b7 = slot_b_q[7];

endmodule

// File: tb/tb_dot_product_stream_loader.sv
// Directed plus randomized bench for dot_product_stream_loader with a behavioural accelerator.
module tb_dot_product_stream_loader;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 64;
    localparam int unsigned TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, s_last;
    logic [DW-1:0] s_a, s_b;
    logic          acc_start, acc_done;
    logic [RW-1:0] acc_result;
    logic [DW-1:0] acc_a0, acc_a1, acc_a2, acc_a3, acc_a4, acc_a5, acc_a6, acc_a7;
    logic [DW-1:0] acc_b0, acc_b1, acc_b2, acc_b3, acc_b4, acc_b5, acc_b6, acc_b7;
    logic          m_valid, m_ready, m_err, busy, timeout_err;
    logic [RW-1:0] m_result;

    logic [DW-1:0] acc_a [8];
    logic [DW-1:0] acc_b [8];

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;
    int model_hold = 1;
    int model_gap  = 2;
    bit model_never = 1'b0;

    logic signed [DW-1:0] va [8];
    logic signed [DW-1:0] vb [8];

    always #5 clk = ~clk;

    dot_product_stream_loader #(
        .DATA_W(DW), .RESULT_W(RW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_a(s_a), .s_b(s_b), .s_last(s_last),
        .acc_start(acc_start),
        .acc_a0(acc_a0), .acc_a1(acc_a1), .acc_a2(acc_a2), .acc_a3(acc_a3),
        .acc_a4(acc_a4), .acc_a5(acc_a5), .acc_a6(acc_a6), .acc_a7(acc_a7),
        .acc_b0(acc_b0), .acc_b1(acc_b1), .acc_b2(acc_b2), .acc_b3(acc_b3),
        .acc_b4(acc_b4), .acc_b5(acc_b5), .acc_b6(acc_b6), .acc_b7(acc_b7),
        .acc_done(acc_done), .acc_result(acc_result),
        .m_valid(m_valid), .m_ready(m_ready), .m_result(m_result), .m_err(m_err),
        .busy(busy), .timeout_err(timeout_err)
    );

    assign acc_a[0] = acc_a0; assign acc_a[1] = acc_a1; assign acc_a[2] = acc_a2; assign acc_a[3] = acc_a3;
    assign acc_a[4] = acc_a4; assign acc_a[5] = acc_a5; assign acc_a[6] = acc_a6; assign acc_a[7] = acc_a7;
    assign acc_b[0] = acc_b0; assign acc_b[1] = acc_b1; assign acc_b[2] = acc_b2; assign acc_b[3] = acc_b3;
    assign acc_b[4] = acc_b4; assign acc_b[5] = acc_b5; assign acc_b[6] = acc_b6; assign acc_b[7] = acc_b7;

    always @(negedge clk) if (acc_start === 1'b1) start_cnt++;

    // Accelerator model: done idles high, drops model_hold cycles after start, rises model_gap later.
    initial begin : accel_model
        longint sum;
        acc_done   = 1'b1;
        acc_result = '0;
        forever begin
            @(negedge clk);
            if (acc_start === 1'b1 && rst === 1'b0) begin
                sum = 0;
                for (int i = 0; i < 8; i++)
                    sum += longint'($signed(acc_a[i])) * longint'($signed(acc_b[i]));
                repeat (model_hold) @(negedge clk);
                acc_done = 1'b0;
                if (!model_never) begin
                    repeat (model_gap) @(negedge clk);
                    acc_result = sum;
                    acc_done   = 1'b1;
                end
            end
        end
    end

    function automatic longint ref_dot(int n);
        longint s = 0;
        for (int i = 0; i < n; i++) s += longint'(va[i]) * longint'(vb[i]);
        return s;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_s_ready"}, 64'(s_ready), 64'd1);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_acc_start"}, 64'(acc_start), 64'd0);
        check({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        check({tag, "_m_result"}, m_result, 64'd0);
        check({tag, "_m_err"}, 64'(m_err), 64'd0);
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'd0);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_acc_a%0d", tag, i), 64'(acc_a[i]), 64'd0);
            check($sformatf("%s_acc_b%0d", tag, i), 64'(acc_b[i]), 64'd0);
        end
    endtask

    // Streams va/vb[0..n-1]; checks start timing and operand/padding contents at the start cycle.
    task automatic send_vec(input int n, input bit last_flag);
        int w;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            s_valid = 1'b1;
            s_a     = va[i];
            s_b     = vb[i];
            s_last  = last_flag && (i == n - 1);
            w = 0;
            while (s_ready !== 1'b1 && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (w >= 200) begin
                check("s_ready_wait", 64'(s_ready), 64'd1);
                s_valid = 1'b0;
                return;
            end
            @(posedge clk);
        end
        @(negedge clk);
        s_valid = 1'b0;
        s_last  = 1'b0;
        check("acc_start_high", 64'(acc_start), 64'd1);
        check("busy_at_start", 64'(busy), 64'd1);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("acc_a%0d", i), 64'(acc_a[i]), (i < n) ? 64'($unsigned(va[i])) : 64'd0);
            check($sformatf("acc_b%0d", i), 64'(acc_b[i]), (i < n) ? 64'($unsigned(vb[i])) : 64'd0);
        end
        @(negedge clk);
        check("acc_start_pulse", 64'(acc_start), 64'd0);
    endtask

    task automatic wait_result(input string tag, input longint exp, input bit exp_err, output int w);
        w = 0;
        while (m_valid !== 1'b1 && w < 300) begin
            @(negedge clk);
            w++;
        end
        check({tag, "_m_valid"}, 64'(m_valid), 64'd1);
        check({tag, "_m_result"}, m_result, exp);
        check({tag, "_m_err"}, 64'(m_err), 64'(exp_err));
        check({tag, "_timeout_err"}, 64'(timeout_err), 64'(exp_err));
    endtask

    task automatic handshake(input string tag);
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_ready = 1'b0;
        check({tag, "_m_valid_low"}, 64'(m_valid), 64'd0);
        check({tag, "_s_ready_back"}, 64'(s_ready), 64'd1);
        check({tag, "_busy_low"}, 64'(busy), 64'd0);
    endtask

    task automatic run_vec(input string tag, input int n, input bit last_flag, input longint exp);
        int s0;
        int w;
        s0 = start_cnt;
        send_vec(n, last_flag);
        wait_result(tag, exp, 1'b0, w);
        check({tag, "_start_count"}, 64'(start_cnt - s0), 64'd1);
        handshake(tag);
    endtask

    initial begin : main
        int w;
        int n;
        logic [63:0] held;
        rst = 1'b1; s_valid = 1'b0; s_a = '0; s_b = '0; s_last = 1'b0; m_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle("reset");
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin va[i] = 32'(i + 1); vb[i] = 32'(i + 1); end
        run_vec("full", 8, 1'b1, 64'd204);

        va[0] = 2; va[1] = 3; va[2] = 4; vb[0] = 5; vb[1] = 6; vb[2] = 7;
        run_vec("short", 3, 1'b1, 64'd56);

        va[0] = -3; va[1] = 7; vb[0] = 5; vb[1] = -2;
        run_vec("signed", 2, 1'b1, -64'sd29);

        // Stale done: previous result 400 still presented while done is held high
        va[0] = 20; vb[0] = 20;
        run_vec("pre_stale", 1, 1'b1, 64'd400);
        model_hold = 3; model_gap = 4;
        va[0] = 9; va[1] = -4; vb[0] = 11; vb[1] = 6;
        run_vec("stale", 2, 1'b1, 64'd75);
        model_hold = 1; model_gap = 2;

        // Backpressure: result must hold and input must stay blocked
        va[0] = 100; va[1] = -50; va[2] = 3; vb[0] = -7; vb[1] = -9; vb[2] = 1000;
        send_vec(3, 1'b1);
        wait_result("bp", ref_dot(3), 1'b0, w);
        held = m_result;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            s_valid = k[0];
            s_a = 32'hDEAD_0000 + 32'(k);
            s_b = 32'h0000_BEEF;
            check("bp_m_valid_hold", 64'(m_valid), 64'd1);
            check("bp_m_result_hold", m_result, 64'(ref_dot(3)));
            check("bp_s_ready_low", 64'(s_ready), 64'd0);
        end
        s_valid = 1'b0;
        handshake("bp");
        check("bp_held_value", held, 64'(ref_dot(3)));

        for (int t = 0; t < 6; t++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < 8; i++) begin va[i] = $urandom; vb[i] = $urandom; end
            run_vec($sformatf("rand%0d", t), n, (n < 8) ? 1'b1 : 1'($urandom_range(0, 1)), ref_dot(n));
        end

        // Timeout: the accelerator never completes
        model_never = 1'b1;
        va[0] = 5; va[1] = 6; vb[0] = 7; vb[1] = 8;
        send_vec(2, 1'b1);
        wait_result("timeout", 64'd0, 1'b1, w);
        check("timeout_latency_window", 64'(w >= 15 && w <= 17), 64'd1);
        @(negedge clk);
        m_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_ready = 1'b0;
        check("timeout_sticky", 64'(timeout_err), 64'd1);
        check("timeout_s_ready_back", 64'(s_ready), 64'd1);

        // Two beats into LOAD, then reset
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_a = 32'h1234 + 32'(i); s_b = 32'h77; s_last = 1'b0;
            @(posedge clk);
            @(negedge clk);
        end
        s_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_idle("mid_rst");
        model_never = 1'b0;

        for (int i = 0; i < 8; i++) begin va[i] = 32'(i + 1); vb[i] = 32'(i + 1); end
        run_vec("after_rst", 8, 1'b1, 64'd204);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
